instruction_fetch_unit: RTL and testbench

- Upstream neighbour of the main controller in the RISC-V datapath.
- Owns the PC register and issues in-order requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions in a small FIFO and presents them, with opcode split out, to decode/controller.
- Handles taken-branch redirects from the branch AND gate, flushing the buffer and dropping stale responses.

---
 rtl/riscv_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcodes, fetch FSM states and PC step for the RISC-V datapath
package riscv_pkg;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam int         PC_STEP  = 4;
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of {instruction, PC} pairs with flush
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int IW    = 32,
    parameter int AW    = 64,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [IW-1:0] push_instr,
    input  logic [AW-1:0] push_pc,
    input  logic          pop,
    input  logic          flush,
    output logic [IW-1:0] head_instr,
    output logic [AW-1:0] head_pc,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [IW-1:0] instr_mem_q [DEPTH];
    logic [AW-1:0] pc_mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full       = cnt_q == CW'(DEPTH);
    assign empty      = cnt_q == '0;
    assign count      = cnt_q;
    assign head_instr = instr_mem_q[rd_q];
    assign head_pc    = pc_mem_q[rd_q];

    // Pointer and occupancy update; flush empties the queue and beats any push/pop
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = flush ? '0 : do_push ? ((wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1)) : wr_q;
        rd_d    = flush ? '0 : do_pop ? ((rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1)) : rd_q;
        cnt_d   = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Registered pointers, occupancy and entry storage
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push && !flush) begin
                instr_mem_q[wr_q] <= push_instr;
                pc_mem_q[wr_q]    <= push_pc;
            end
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner, in-order imem requester and instruction buffer.
// MISALIGN_TRAP_EN: misaligned redirects are ignored and raise a sticky misalign_fault.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    FIFO_DEPTH  = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic [6:0]             opcode
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                   misalign_fault
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    fetch_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d, target, head_pc;
    logic [ADDR_WIDTH-1:0]  tag_q [FIFO_DEPTH];
    logic [PW-1:0]          tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CW-1:0]          out_q, out_d, drop_q, drop_d, fifo_count;
    logic [INSTR_WIDTH-1:0] head_instr;
    logic                   redirect, accept, rsp_eff, rsp_push, fifo_full, fifo_empty;

`ifdef MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    assign redirect       = branch_taken && branch_target[1:0] == 2'b00;
    assign target         = branch_target;
    assign fault_d        = fault_q || (branch_taken && !redirect);
    assign misalign_fault = fault_q;

    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clock) begin
        if (!reset_n) fault_q <= 1'b0;
        else fault_q <= fault_d;
    end
`else
    assign redirect = branch_taken;
    assign target   = branch_target & ~ADDR_WIDTH'(3);
`endif

    assign imem_req_valid = state_q == S_RUN && !redirect && !fifo_full &&
                            (32'(out_q) + 32'(fifo_count)) < 32'(FIFO_DEPTH);
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_eff        = imem_rsp_valid && out_q != '0;
    assign rsp_push       = rsp_eff && drop_q == '0 && !redirect;
    assign instr_valid    = !fifo_empty;
    assign instr          = fifo_empty ? '0 : head_instr;
    assign instr_pc       = fifo_empty ? '0 : head_pc;
    assign opcode         = instr[6:0];

    // Next PC, outstanding/drop counters, PC tag pointers and fetch state
    always_comb begin
        pc_d     = redirect ? target : accept ? pc_q + ADDR_WIDTH'(PC_STEP) : pc_q;
        out_d    = out_q + CW'(accept) - CW'(rsp_eff);
        drop_d   = redirect ? out_d : (rsp_eff && drop_q != '0) ? drop_q - CW'(1) : drop_q;
        tag_wr_d = redirect ? '0 : accept ? ((tag_wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : tag_wr_q + PW'(1)) : tag_wr_q;
        tag_rd_d = redirect ? '0 : rsp_push ? ((tag_rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : tag_rd_q + PW'(1)) : tag_rd_q;
        state_d  = redirect ? ((drop_d != '0) ? S_FLUSH : S_RUN) :
                   state_q == S_BOOT ? S_RUN :
                   (state_q == S_FLUSH && drop_d == '0) ? S_RUN : state_q;
    end

    // Registered fetch state; tags remember the PC of every live request in order
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
            if (accept) tag_q[tag_wr_q] <= pc_q;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .IW    (INSTR_WIDTH),
        .AW    (ADDR_WIDTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (rsp_push),
        .push_instr (imem_rsp_data),
        .push_pc    (tag_q[tag_rd_q]),
        .pop        (instr_valid && instr_ready),
        .flush      (redirect),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed and random checks against a transaction-level fetch model
module tb_instruction_fetch_unit;
    localparam int AW = 64, IW = 32, DEPTH = 2;

    logic          clock = 1'b0, reset_n = 1'b0;
    logic          imem_req_valid, imem_req_ready = 1'b0;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [IW-1:0] imem_rsp_data = '0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          instr_valid, instr_ready = 1'b0;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic [6:0]    opcode;
`ifdef MISALIGN_TRAP_EN
    logic          misalign_fault;
`endif

    int checks = 0, errors = 0;

    always #5 clock = ~clock;

    instruction_fetch_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    typedef struct { logic [AW-1:0] pc; logic [IW-1:0] data; int due; bit stale; } mem_t;
    typedef struct { logic [AW-1:0] pc; logic [IW-1:0] data; } ent_t;

    mem_t          pend[$];
    ent_t          expq[$];
    logic [AW-1:0] mpc = '0;
    int            cyc = 0, since_rst = 0, last_due = 0, lat_min = 1, lat_max = 1, nacc = 0;
    bit            force_rsp = 0, mfault = 0;
    logic          l_req_valid, l_instr_valid;
    logic [AW-1:0] l_addr, l_instr_pc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: memory drives its response, outputs are checked mid-cycle, model advances
    task automatic step();
        bit   redir, misal, acc, exp_req;
        int   stale, lat, due;
        mem_t m;
        imem_rsp_valid = force_rsp || (pend.size() > 0 && pend[0].due <= cyc);
        imem_rsp_data  = (pend.size() > 0) ? pend[0].data : '0;
        @(negedge clock);
        misal = branch_taken && branch_target[1:0] != 2'b00;
`ifdef MISALIGN_TRAP_EN
        redir = branch_taken && !misal;
`else
        redir = branch_taken;
`endif
        stale = 0;
        foreach (pend[i]) if (pend[i].stale) stale++;
        exp_req = since_rst >= 1 && stale == 0 && (pend.size() + expq.size()) < DEPTH && !redir;
        check("req_valid", 64'(imem_req_valid), 64'(exp_req));
        if (exp_req) check("req_addr", imem_req_addr, mpc);
        check("instr_valid", 64'(instr_valid), 64'(expq.size() > 0));
        if (expq.size() > 0) begin
            check("instr_pc", instr_pc, expq[0].pc);
            check("instr", 64'(instr), 64'(expq[0].data));
            check("opcode", 64'(opcode), 64'(expq[0].data[6:0]));
        end
`ifdef MISALIGN_TRAP_EN
        check("misalign_fault", 64'(misalign_fault), 64'(mfault));
`endif
        l_req_valid   = imem_req_valid;
        l_addr        = imem_req_addr;
        l_instr_valid = instr_valid;
        l_instr_pc    = instr_pc;
        acc = exp_req && imem_req_ready;
        if (expq.size() > 0 && instr_ready) void'(expq.pop_front());
        if (imem_rsp_valid && pend.size() > 0) begin
            m = pend.pop_front();
            if (!m.stale && !redir) expq.push_back('{m.pc, m.data});
        end
        if (redir) begin
            expq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            mpc = branch_target & ~64'h3;
        end
        if (misal) mfault = 1'b1;
        if (acc) begin
            lat = lat_min + int'($urandom_range(0, lat_max - lat_min));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{mpc, IW'($urandom), due, 1'b0});
            mpc = mpc + 64'd4;
            nacc++;
        end
        since_rst++;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        imem_rsp_valid = 1'b0;
        branch_taken   = 1'b0;
        force_rsp      = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_req_addr", imem_req_addr, 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_instr_pc", instr_pc, 64'd0);
        check("rst_opcode", 64'(opcode), 64'd0);
`ifdef MISALIGN_TRAP_EN
        check("rst_fault", 64'(misalign_fault), 64'd0);
`endif
        pend.delete();
        expq.delete();
        mpc       = '0;
        since_rst = 0;
        last_due  = 0;
        mfault    = 1'b0;
        reset_n   = 1'b1;
    endtask

    task automatic wait_req(input string tag, input logic [AW-1:0] addr);
        bit found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            found = l_req_valid;
        end
        check({tag, "_seen"}, 64'(found), 64'd1);
        if (found) check(tag, l_addr, addr);
    endtask

    task automatic wait_instr(input string tag, input logic [AW-1:0] pc);
        bit found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            found = l_instr_valid;
        end
        check({tag, "_seen"}, 64'(found), 64'd1);
        if (found) check(tag, l_instr_pc, pc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming with 1-cycle memory and an always-ready consumer
        lat_min = 1; lat_max = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        do_reset();
        step(); check("t1_boot_idle", 64'(l_req_valid), 64'd0);
        step(); check("t1_c1_valid", 64'(l_req_valid), 64'd1); check("t1_c1_addr", l_addr, 64'h0);
        step(); check("t1_c2_addr", l_addr, 64'h4); check("t1_c2_no_instr", 64'(l_instr_valid), 64'd0);
        step(); check("t1_c3_instr", 64'(l_instr_valid), 64'd1); check("t1_c3_pc", l_instr_pc, 64'h0);
        step(); check("t1_c4_addr", l_addr, 64'h8); check("t1_c4_pc", l_instr_pc, 64'h4);
        step(); step(); check("t1_c6_pc", l_instr_pc, 64'h8);
        // Consumer stall caps requests at the buffer depth, then resumes in order
        do_reset();
        instr_ready = 1'b0; nacc = 0;
        repeat (8) step();
        check("t2_accepts", 64'(nacc), 64'd2);
        check("t2_stalled", 64'(l_req_valid), 64'd0);
        instr_ready = 1'b1;
        repeat (10) step();
        // Redirect with two requests in flight drops both responses
        do_reset();
        lat_min = 3; lat_max = 3; nacc = 0;
        repeat (3) step();
        check("t3_outstanding", 64'(nacc), 64'd2);
        branch_taken = 1'b1; branch_target = 64'h100;
        step();
        branch_taken = 1'b0;
        wait_req("t3_first_addr", 64'h100);
        wait_instr("t3_first_pc", 64'h100);
        // Redirect coinciding with a response and a pop
        do_reset();
        lat_min = 2; lat_max = 2;
        repeat (4) step();
        branch_taken = 1'b1; branch_target = 64'h200;
        step();
        branch_taken = 1'b0;
        check("t4_head_popped", 64'(l_instr_valid), 64'd1);
        check("t4_rsp_same_cycle", 64'(imem_rsp_valid), 64'd1);
        step();
        check("t4_flushed", 64'(l_instr_valid), 64'd0);
        check("t4_req_valid", 64'(l_req_valid), 64'd1);
        check("t4_req_addr", l_addr, 64'h200);
        // PC wraps silently at the top of the address space
        branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        branch_taken = 1'b0;
        wait_req("t5_top_addr", 64'hFFFF_FFFF_FFFF_FFFC);
        wait_req("t5_wrap_addr", 64'h0);
        // Misaligned redirect target
        repeat (4) step();
        branch_taken = 1'b1; branch_target = 64'h102;
        step();
        branch_taken = 1'b0;
`ifdef MISALIGN_TRAP_EN
        step();
        check("t6_fault", 64'(misalign_fault), 64'd1);
`else
        wait_req("t6_aligned_addr", 64'h100);
`endif
        // Response with nothing outstanding is ignored
        do_reset();
        imem_req_ready = 1'b0;
        repeat (2) step();
        force_rsp = 1'b1;
        step();
        force_rsp = 1'b0;
        step();
        check("t7_spurious", 64'(l_instr_valid), 64'd0);
        // Randomised traffic with variable latency, backpressure, redirects and resets
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) do_reset();
            imem_req_ready = $urandom_range(0, 3) != 0;
            instr_ready    = $urandom_range(0, 3) != 0;
            branch_taken   = $urandom_range(0, 19) == 0;
            branch_target  = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 7) != 0) branch_target[1:0] = 2'b00;
            step();
        end
        branch_taken = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
